regbank_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer for a small bank of 8-bit enable-loaded registers. Each requester issues single read or write transactions through a req/ack handshake. The block serialises access, generates per-register load enables and a bank-wide clear, and returns read data. It sits between two independent datapath masters and the shared register bank that it instantiates.

---
 rtl/regbank_arbiter_pkg.sv | 8 +
 rtl/regbank_arbiter_slot.sv | 21 ++
 rtl/regbank_arbiter.sv | 73 +++++++
 tb/tb_regbank_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regbank_arbiter_pkg.sv
// regbank_arbiter_pkg: FSM encoding, default sizes and requester ids shared by the register-bank arbiter
package regbank_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SERVE = 2'd1, ACK = 2'd2} state_t;
  localparam int W_DEF = 8;
  localparam int NREG_DEF = 4;
  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;
endpackage

// File: rtl/regbank_arbiter_slot.sv
// reg_slot: one W-bit bank register with synchronous clear and load enable
//   clk    rising-edge clock
//   clr_i  synchronous clear, wins over load
//   le_i   load enable
//   d_i    load data
//   q_o    register contents
module reg_slot
  import regbank_arbiter_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         clr_i,
  input  logic         le_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] q_q;
  always_ff @(posedge clk) q_q <= clr_i ? '0 : le_i ? d_i : q_q;
  assign q_o = q_q;
endmodule

// File: rtl/regbank_arbiter.sv
// regbank_arbiter: two-requester round-robin sequencer for a bank of enable-loaded registers
//   clk, reset           clock and synchronous active-high reset
//   clr_all              bank-wide clear, honoured only in IDLE
//   req/we/addr/wdata0,1 per-requester transaction inputs
//   ack0/1, rdata0/1     per-requester completion pulse and read result
//   busy, gnt_id         not-IDLE flag and requester being served
module regbank_arbiter
  import regbank_arbiter_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int W = W_DEF,
  localparam int AW = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_all,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [W-1:0]  wdata0,
  input  logic [W-1:0]  wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic [W-1:0]  rdata0,
  output logic [W-1:0]  rdata1,
  output logic          busy,
  output logic          gnt_id
);
  state_t state_q, state_d;
  logic gnt_q, gnt_d, last_q, start, clr, sel_we;
  logic [AW-1:0] sel_addr;
  logic [W-1:0] sel_wdata, rd_val, rdata0_q, rdata1_q;
  logic [NREG-1:0] le;
  logic [W-1:0] q [NREG];
  assign start = state_q == IDLE && !clr_all && (req0 || req1);
  // on a tie the requester not served last wins
  assign gnt_d = start ? ((req0 && req1) ? ~last_q : req1) : gnt_q;
  assign sel_we = gnt_q ? we1 : we0;
  assign sel_addr = gnt_q ? addr1 : addr0;
  assign sel_wdata = gnt_q ? wdata1 : wdata0;
  always_ff @(posedge clk) state_q <= reset ? IDLE : state_d;
  always_comb begin
    state_d = state_q == IDLE ? (start ? SERVE : IDLE) : state_q == SERVE ? ACK : IDLE;
  end
  // ack is gated by reset so a reset landing in ACK swallows the pulse
  always_comb begin
    busy = state_q != IDLE;
    ack0 = state_q == ACK && gnt_q == REQ0 && !reset;
    ack1 = state_q == ACK && gnt_q == REQ1 && !reset;
    clr = reset || (state_q == IDLE && clr_all);
    for (int i = 0; i < NREG; i++) le[i] = state_q == SERVE && sel_we && sel_addr == AW'(i);
  end
  // out-of-range addresses match no slot and read back as zero
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NREG; i++) rd_val = sel_addr == AW'(i) ? q[i] : rd_val;
  end
  always_ff @(posedge clk) begin
    gnt_q <= reset ? REQ0 : gnt_d;
    last_q <= reset ? REQ1 : state_q == ACK ? gnt_q : last_q;
    rdata0_q <= reset ? '0 : (state_q == SERVE && gnt_q == REQ0 && !sel_we) ? rd_val : rdata0_q;
    rdata1_q <= reset ? '0 : (state_q == SERVE && gnt_q == REQ1 && !sel_we) ? rd_val : rdata1_q;
  end
  for (genvar i = 0; i < NREG; i++) begin : g_slot
    reg_slot #(.W(W)) u_slot (.clk(clk), .clr_i(clr), .le_i(le[i]), .d_i(sel_wdata), .q_o(q[i]));
  end
  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;
  assign gnt_id = gnt_q;
endmodule

// File: tb/tb_regbank_arbiter.sv
// tb_regbank_arbiter: directed and random checks of regbank_arbiter (NREG=4 and NREG=3) against a transaction-level model
module tb_regbank_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clr_all = 1'b0;
  logic rq [2];
  logic wq [2];
  logic [1:0] aq [2];
  logic [7:0] dq [2];
  logic ack0, ack1, busy, gnt_id;
  logic [7:0] rdata0, rdata1;
  logic x_ack0, x_ack1, x_busy, x_gnt_id;
  logic [7:0] x_rdata0, x_rdata1;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  regbank_arbiter #(.NREG(4), .W(8)) dut (
    .clk(clk), .reset(reset), .clr_all(clr_all),
    .req0(rq[0]), .req1(rq[1]), .we0(wq[0]), .we1(wq[1]),
    .addr0(aq[0]), .addr1(aq[1]), .wdata0(dq[0]), .wdata1(dq[1]),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .busy(busy), .gnt_id(gnt_id));

  regbank_arbiter #(.NREG(3), .W(8)) dut3 (
    .clk(clk), .reset(reset), .clr_all(clr_all),
    .req0(rq[0]), .req1(rq[1]), .we0(wq[0]), .we1(wq[1]),
    .addr0(aq[0]), .addr1(aq[1]), .wdata0(dq[0]), .wdata1(dq[1]),
    .ack0(x_ack0), .ack1(x_ack1), .rdata0(x_rdata0), .rdata1(x_rdata1),
    .busy(x_busy), .gnt_id(x_gnt_id));

  function automatic void chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h t=%0t", n, act, exp, $time);
    end
  endfunction

  // transaction-level model: a transaction started in idle cycle s is served at s+1 and acked at s+2
  int cyc = 0;
  int s_cyc = -100;
  bit armed = 1'b0;
  bit who = 1'b0;
  bit last = 1'b1;
  bit gid = 1'b0;
  bit m_we = 1'b0;
  int m_a = 0;
  logic [7:0] m_d = 8'h00;
  logic [7:0] mem [4];
  logic [7:0] mem3 [4];
  logic [7:0] mrd [2];
  logic [7:0] mrd3 [2];
  bit mack [2];

  always @(negedge clk) begin
    cyc++;
    mack[0] = armed && !reset && cyc == s_cyc + 2 && who == 1'b0;
    mack[1] = armed && !reset && cyc == s_cyc + 2 && who == 1'b1;
    if (armed) begin
      chk("busy", 32'(busy), 32'(cyc == s_cyc + 1 || cyc == s_cyc + 2));
      chk("ack0", 32'(ack0), 32'(mack[0]));
      chk("ack1", 32'(ack1), 32'(mack[1]));
      chk("gnt_id", 32'(gnt_id), 32'(gid));
      chk("rdata0", 32'(rdata0), 32'(mrd[0]));
      chk("rdata1", 32'(rdata1), 32'(mrd[1]));
      chk("n3_busy", 32'(x_busy), 32'(cyc == s_cyc + 1 || cyc == s_cyc + 2));
      chk("n3_ack0", 32'(x_ack0), 32'(mack[0]));
      chk("n3_ack1", 32'(x_ack1), 32'(mack[1]));
      chk("n3_rdata0", 32'(x_rdata0), 32'(mrd3[0]));
      chk("n3_rdata1", 32'(x_rdata1), 32'(mrd3[1]));
    end
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        mem[i] = 8'h00;
        mem3[i] = 8'h00;
      end
      for (int i = 0; i < 2; i++) begin
        mrd[i] = 8'h00;
        mrd3[i] = 8'h00;
      end
      last = 1'b1;
      gid = 1'b0;
      s_cyc = -100;
      armed = 1'b1;
    end else if (cyc == s_cyc + 1) begin
      if (m_we) begin
        mem[m_a] = m_d;
        if (m_a < 3) mem3[m_a] = m_d;
      end else begin
        mrd[who] = mem[m_a];
        mrd3[who] = (m_a < 3) ? mem3[m_a] : 8'h00;
      end
    end else if (cyc == s_cyc + 2) begin
      last = who;
    end else if (clr_all) begin
      for (int i = 0; i < 4; i++) begin
        mem[i] = 8'h00;
        mem3[i] = 8'h00;
      end
    end else if (rq[0] || rq[1]) begin
      who = (rq[0] && rq[1]) ? !last : rq[1];
      gid = who;
      s_cyc = cyc;
      m_we = wq[who];
      m_a = int'(aq[who]);
      m_d = dq[who];
    end
  end

  task automatic txn(input int r, input logic w, input logic [1:0] a, input logic [7:0] d,
                     output int lat, output logic [7:0] rd, output logic [7:0] xrd);
    rq[r] = 1'b1;
    wq[r] = w;
    aq[r] = a;
    dq[r] = d;
    lat = -1;
    rd = 8'hxx;
    xrd = 8'hxx;
    for (int k = 1; k <= 12 && lat < 0; k++) begin
      @(posedge clk); #1;
      if (r == 1 ? ack1 : ack0) begin
        lat = k;
        rd = r == 1 ? rdata1 : rdata0;
        xrd = r == 1 ? x_rdata1 : x_rdata0;
      end
    end
    @(posedge clk); #1;
    rq[r] = 1'b0;
  endtask

  task automatic tie(output int l0, output int l1);
    rq[0] = 1'b1;
    rq[1] = 1'b1;
    wq[0] = 1'b0;
    wq[1] = 1'b0;
    aq[0] = 2'd0;
    aq[1] = 2'd1;
    l0 = -1;
    l1 = -1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (l0 > 0) rq[0] = 1'b0;
      if (l1 > 0) rq[1] = 1'b0;
      if (ack0 && l0 < 0) l0 = k;
      if (ack1 && l1 < 0) l1 = k;
    end
    rq[0] = 1'b0;
    rq[1] = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  int lat, l0, l1;
  logic [7:0] rd, xrd;

  initial begin
    for (int i = 0; i < 2; i++) begin
      rq[i] = 1'b0;
      wq[i] = 1'b0;
      aq[i] = 2'd0;
      dq[i] = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_busy", 32'(busy), 0);
    chk("reset_gnt", 32'(gnt_id), 0);
    txn(0, 1'b0, 2'd2, 8'h00, lat, rd, xrd);
    chk("read_lat", lat, 2);
    chk("read_r2", 32'(rd), 'h00);
    txn(0, 1'b1, 2'd1, 8'hA5, lat, rd, xrd);
    chk("write_lat", lat, 2);
    txn(1, 1'b0, 2'd1, 8'h00, lat, rd, xrd);
    chk("rd1_a5", 32'(rd), 'hA5);
    chk("rd0_kept", 32'(rdata0), 'h00);
    do_reset();
    tie(l0, l1);
    chk("tie1_l0", l0, 2);
    chk("tie1_l1", l1, 5);
    txn(0, 1'b0, 2'd0, 8'h00, lat, rd, xrd);
    tie(l0, l1);
    chk("tie2_l1", l1, 2);
    chk("tie2_l0", l0, 5);
    for (int i = 0; i < 4; i++) txn(1, 1'b1, 2'(i), 8'((i + 1) * 17), lat, rd, xrd);
    txn(0, 1'b0, 2'd3, 8'h00, lat, rd, xrd);
    chk("fill_r3", 32'(rd), 'h44);
    clr_all = 1'b1;
    @(posedge clk); #1;
    clr_all = 1'b0;
    chk("clr_busy", 32'(busy), 0);
    chk("clr_noack", 32'(ack0 | ack1), 0);
    for (int i = 0; i < 4; i++) begin
      txn(0, 1'b0, 2'(i), 8'h00, lat, rd, xrd);
      chk("clr_read", 32'(rd), 'h00);
    end
    rq[1] = 1'b1;
    wq[1] = 1'b1;
    aq[1] = 2'd3;
    dq[1] = 8'h7E;
    @(posedge clk); #1;
    chk("serve_busy", 32'(busy), 1);
    reset = 1'b1;
    rq[1] = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_serve_idle", 32'(busy), 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("rst_serve_noack", 32'(ack1), 0);
    end
    txn(0, 1'b0, 2'd3, 8'h00, lat, rd, xrd);
    chk("rst_serve_r3", 32'(rd), 'h00);
    txn(0, 1'b1, 2'd0, 8'h3C, lat, rd, xrd);
    rq[0] = 1'b1;
    wq[0] = 1'b0;
    aq[0] = 2'd0;
    repeat (2) @(posedge clk);
    #1 chk("ack_busy", 32'(busy), 1);
    reset = 1'b1;
    #1 chk("rst_ack_gated", 32'(ack0), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    rq[0] = 1'b0;
    chk("rst_ack_idle", 32'(busy), 0);
    txn(0, 1'b1, 2'd2, 8'h5A, lat, rd, xrd);
    txn(0, 1'b1, 2'd3, 8'hFF, lat, rd, xrd);
    chk("oor_write_lat", lat, 2);
    txn(0, 1'b0, 2'd3, 8'h00, lat, rd, xrd);
    chk("n4_r3", 32'(rd), 'hFF);
    chk("n3_oor_read", 32'(xrd), 'h00);
    txn(0, 1'b0, 2'd2, 8'h00, lat, rd, xrd);
    chk("n3_r2", 32'(xrd), 'h5A);
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      reset = $urandom_range(0, 199) == 0;
      clr_all = $urandom_range(0, 15) == 0;
      for (int r = 0; r < 2; r++) begin
        if (reset || (rq[r] && mack[r])) rq[r] = 1'b0;
        else if (!rq[r] && $urandom_range(0, 2) == 0) begin
          rq[r] = 1'b1;
          wq[r] = 1'($urandom_range(0, 1));
          aq[r] = 2'($urandom_range(0, 3));
          dq[r] = 8'($urandom);
        end
      end
    end
    @(posedge clk); #1;
    reset = 1'b0;
    clr_all = 1'b0;
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
